// File: rtl/icache_2way_pkg.sv
// Shared types and defaults for the 2-way set-associative instruction cache.
package icache_2way_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    localparam int DEFAULT_ADDR_WIDTH  = 32;
    localparam int DEFAULT_INDEX_BITS  = 6;
    localparam int DEFAULT_OFFSET_BITS = 2;

    function automatic int tag_width(input int addr_width, input int index_bits, input int offset_bits);
        return addr_width - index_bits - offset_bits - 2;
    endfunction

endpackage

// File: rtl/icache_2way_if.sv
// IF-side fetch port and memory-controller word port of the instruction cache.
interface icache_2way_if #(
    parameter int ADDR_WIDTH = icache_2way_pkg::DEFAULT_ADDR_WIDTH
) ();

    logic                  if_valid;
    logic [ADDR_WIDTH-1:0] pc_from_if;
    logic                  inst_enable;
    logic [31:0]           inst_to_if;
    logic                  addr_enable;
    logic [ADDR_WIDTH-1:0] addr_to_mem;
    logic                  mem_accept;
    logic                  mem_valid;
    logic [31:0]           inst_from_mem;

    modport slave (
        input  if_valid, pc_from_if, mem_accept, mem_valid, inst_from_mem,
        output inst_enable, inst_to_if, addr_enable, addr_to_mem
    );

    modport master (
        output if_valid, pc_from_if, mem_accept, mem_valid, inst_from_mem,
        input  inst_enable, inst_to_if, addr_enable, addr_to_mem
    );

endinterface

// File: rtl/icache_2way_way.sv
// One way of the cache: valid/tag/data arrays with combinational lookup,
// word write during refill, line commit and whole-way invalidation.
module icache_2way_way
    import icache_2way_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int INDEX_BITS  = DEFAULT_INDEX_BITS,
    parameter int OFFSET_BITS = DEFAULT_OFFSET_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_BITS-1:0]  rd_set,
    input  logic [OFFSET_BITS-1:0] rd_offset,
    input  logic [tag_width(ADDR_WIDTH, INDEX_BITS, OFFSET_BITS)-1:0] rd_tag,
    output logic                   rd_valid,
    output logic                   hit,
    output logic [31:0]            rd_data,
    input  logic [INDEX_BITS-1:0]  wr_set,
    input  logic [OFFSET_BITS-1:0] wr_offset,
    input  logic                   wr_en,
    input  logic [31:0]            wr_data,
    input  logic                   commit_en,
    input  logic                   commit_valid,
    input  logic [tag_width(ADDR_WIDTH, INDEX_BITS, OFFSET_BITS)-1:0] commit_tag,
    input  logic                   flush_clear
);

    localparam int SETS  = 2 ** INDEX_BITS;
    localparam int WORDS = 2 ** (INDEX_BITS + OFFSET_BITS);
    localparam int TAG_W = tag_width(ADDR_WIDTH, INDEX_BITS, OFFSET_BITS);

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    logic [31:0]      data [WORDS];

    assign rd_valid = valid[rd_set];
    assign hit      = rd_valid && (tags[rd_set] == rd_tag);
    assign rd_data  = data[{rd_set, rd_offset}];

    // Invalidation takes priority over a commit landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= '0;
        end else if (flush_clear) begin
            valid <= '0;
        end else if (commit_en) begin
            valid[wr_set] <= commit_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data[{wr_set, wr_offset}] <= wr_data;
        end
        if (commit_en) begin
            tags[wr_set] <= commit_tag;
        end
    end

endmodule

// File: rtl/icache_2way.sv
// 2-way set-associative instruction cache with burst refill, early restart,
// pseudo-LRU replacement and fence.i flush.
module icache_2way
    import icache_2way_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int INDEX_BITS  = DEFAULT_INDEX_BITS,
    parameter int OFFSET_BITS = DEFAULT_OFFSET_BITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         flush,
    icache_2way_if.slave bus
);

    localparam int SETS     = 2 ** INDEX_BITS;
    localparam int TAG_W    = tag_width(ADDR_WIDTH, INDEX_BITS, OFFSET_BITS);
    localparam int TAG_LSB  = INDEX_BITS + OFFSET_BITS + 2;
    localparam int LINE_LSB = OFFSET_BITS + 2;

    logic [OFFSET_BITS-1:0] pc_offset;
    logic [INDEX_BITS-1:0]  pc_set;
    logic [TAG_W-1:0]       pc_tag;

    assign pc_offset = bus.pc_from_if[OFFSET_BITS+1:2];
    assign pc_set    = bus.pc_from_if[TAG_LSB-1:LINE_LSB];
    assign pc_tag    = bus.pc_from_if[ADDR_WIDTH-1:TAG_LSB];

    state_t                 state;
    logic [OFFSET_BITS-1:0] counter;
    logic [ADDR_WIDTH-1:0]  req_pc;
    logic                   victim;
    logic                   flush_pending;
    logic [SETS-1:0]        lru;

    logic [INDEX_BITS-1:0]  line_set;
    logic [TAG_W-1:0]       line_tag;
    logic [OFFSET_BITS-1:0] req_offset;
    logic [OFFSET_BITS-1:0] counter_next;

    assign line_set     = req_pc[TAG_LSB-1:LINE_LSB];
    assign line_tag     = req_pc[ADDR_WIDTH-1:TAG_LSB];
    assign req_offset   = req_pc[OFFSET_BITS+1:2];
    assign counter_next = counter + 1'b1;

    logic        hit0, hit1, valid0, valid1;
    logic [31:0] data0, data1;
    logic        fill_word, fill_last, flush_now, clear_all;
    logic        way_pick;

    // A pending or coincident flush keeps the just-refilled line invalid.
    assign fill_word = rst && rdy && (state == ST_WAIT) && bus.mem_valid;
    assign fill_last = fill_word && (counter == {OFFSET_BITS{1'b1}});
    assign flush_now = flush || flush_pending;
    assign clear_all = rst && rdy && (((state == ST_IDLE) && flush) || (fill_last && flush_now));
    assign way_pick  = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru[pc_set]);

    icache_2way_way #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INDEX_BITS (INDEX_BITS),
        .OFFSET_BITS(OFFSET_BITS)
    ) u_way0 (
        .clk         (clk),
        .rst         (rst),
        .rd_set      (pc_set),
        .rd_offset   (pc_offset),
        .rd_tag      (pc_tag),
        .rd_valid    (valid0),
        .hit         (hit0),
        .rd_data     (data0),
        .wr_set      (line_set),
        .wr_offset   (counter),
        .wr_en       (fill_word && !victim),
        .wr_data     (bus.inst_from_mem),
        .commit_en   (fill_last && !victim),
        .commit_valid(!flush_now),
        .commit_tag  (line_tag),
        .flush_clear (clear_all)
    );

    icache_2way_way #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INDEX_BITS (INDEX_BITS),
        .OFFSET_BITS(OFFSET_BITS)
    ) u_way1 (
        .clk         (clk),
        .rst         (rst),
        .rd_set      (pc_set),
        .rd_offset   (pc_offset),
        .rd_tag      (pc_tag),
        .rd_valid    (valid1),
        .hit         (hit1),
        .rd_data     (data1),
        .wr_set      (line_set),
        .wr_offset   (counter),
        .wr_en       (fill_word && victim),
        .wr_data     (bus.inst_from_mem),
        .commit_en   (fill_last && victim),
        .commit_valid(!flush_now),
        .commit_tag  (line_tag),
        .flush_clear (clear_all)
    );

    // lru[set] names the way to evict next; touching a way points it at the other one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= ST_IDLE;
            counter         <= '0;
            req_pc          <= '0;
            victim          <= 1'b0;
            flush_pending   <= 1'b0;
            lru             <= '0;
            bus.inst_enable <= 1'b0;
            bus.inst_to_if  <= '0;
            bus.addr_enable <= 1'b0;
            bus.addr_to_mem <= '0;
        end else if (!rdy) begin
            bus.inst_enable <= 1'b0;
        end else begin
            bus.inst_enable <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!flush && bus.if_valid) begin
                        if (hit0 || hit1) begin
                            bus.inst_enable <= 1'b1;
                            bus.inst_to_if  <= hit0 ? data0 : data1;
                            lru[pc_set]     <= hit0;
                        end else begin
                            req_pc          <= bus.pc_from_if;
                            victim          <= way_pick;
                            counter         <= '0;
                            state           <= ST_REQ;
                            bus.addr_enable <= 1'b1;
                            bus.addr_to_mem <= {bus.pc_from_if[ADDR_WIDTH-1:LINE_LSB], {OFFSET_BITS{1'b0}}, 2'b00};
                        end
                    end
                end
                ST_REQ: begin
                    if (flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (bus.mem_accept) begin
                        bus.addr_enable <= 1'b0;
                        state           <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (bus.mem_valid) begin
                        if ((counter == req_offset) && bus.if_valid && (bus.pc_from_if == req_pc)) begin
                            bus.inst_enable <= 1'b1;
                            bus.inst_to_if  <= bus.inst_from_mem;
                        end
                        if (counter == {OFFSET_BITS{1'b1}}) begin
                            lru[line_set] <= ~victim;
                            flush_pending <= 1'b0;
                            state         <= ST_IDLE;
                        end else begin
                            counter         <= counter_next;
                            state           <= ST_REQ;
                            bus.addr_enable <= 1'b1;
                            bus.addr_to_mem <= {req_pc[ADDR_WIDTH-1:LINE_LSB], counter_next, 2'b00};
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_2way.sv
// Randomized self-checking bench for icache_2way against a per-set LRU list model.
module tb_icache_2way;

    localparam int AW    = 32;
    localparam int SETS  = 64;
    localparam int WORDS = 4;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic rdy   = 1'b1;
    logic flush = 1'b0;

    icache_2way_if #(.ADDR_WIDTH(AW)) bus ();

    icache_2way #(
        .ADDR_WIDTH (AW),
        .INDEX_BITS (6),
        .OFFSET_BITS(2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rdy  (rdy),
        .flush(flush),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Each set holds up to two resident line tags, ordered most- and least-recently used.
    int          res_cnt [SETS];
    logic [21:0] mru_tag [SETS];
    logic [21:0] lru_tag [SETS];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int s = int'(a[9:4]);
        return (res_cnt[s] >= 1 && mru_tag[s] == a[31:10]) || (res_cnt[s] == 2 && lru_tag[s] == a[31:10]);
    endfunction

    function automatic void model_touch(input logic [31:0] a);
        int s = int'(a[9:4]);
        if (res_cnt[s] == 2 && lru_tag[s] == a[31:10]) begin
            lru_tag[s] = mru_tag[s];
            mru_tag[s] = a[31:10];
        end
    endfunction

    function automatic void model_fill(input logic [31:0] a);
        int s = int'(a[9:4]);
        if (res_cnt[s] == 0) begin
            res_cnt[s] = 1;
        end else begin
            lru_tag[s] = mru_tag[s];
            res_cnt[s] = 2;
        end
        mru_tag[s] = a[31:10];
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++) res_cnt[s] = 0;
    endfunction

    function automatic logic [31:0] randPc();
        logic [31:0] p = 32'h0;
        p[11:10] = 2'($urandom_range(1, 3));
        p[5:4]   = 2'($urandom_range(0, 2));
        p[3:2]   = 2'($urandom_range(0, 3));
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One IF fetch; serves the memory side of any refill and optionally switches pc,
    // flushes, stalls or resets at refill word k.
    task automatic applyStimulus(input logic [31:0] pc, input int switch_k, input logic [31:0] new_pc,
                                 input int flush_k, input int stall_k, input int reset_k);
        logic [31:0] cur, req, base;
        int sw = switch_k;
        int fk = flush_k;
        int sk = stall_k;
        bit pend, fwd, done;
        cur  = pc;
        done = 1'b0;
        bus.if_valid   = 1'b1;
        bus.pc_from_if = cur;
        for (int round = 0; round < 4 && !done; round++) begin
            if (model_hit(cur)) begin
                step();
                checkOutput("hit_en", bus.inst_enable, 1);
                checkOutput("hit_data", bus.inst_to_if, mem_word(cur));
                checkOutput("hit_noreq", bus.addr_enable, 0);
                model_touch(cur);
                done = 1'b1;
            end else begin
                req  = cur;
                base = {cur[31:4], 4'h0};
                pend = 1'b0;
                step();
                checkOutput("miss_en", bus.inst_enable, 0);
                for (int k = 0; k < WORDS; k++) begin
                    checkOutput("req_en", bus.addr_enable, 1);
                    checkOutput("req_addr", bus.addr_to_mem, base + 32'(4 * k));
                    if (k == sk) begin
                        rdy = 1'b0;
                        bus.mem_accept = 1'b1;
                        repeat (5) begin
                            step();
                            checkOutput("stall_en", bus.addr_enable, 1);
                            checkOutput("stall_addr", bus.addr_to_mem, base + 32'(4 * k));
                            checkOutput("stall_inst", bus.inst_enable, 0);
                        end
                        rdy = 1'b1;
                        bus.mem_accept = 1'b0;
                    end
                    repeat ($urandom_range(0, 2)) begin
                        step();
                        checkOutput("req_hold", bus.addr_to_mem, base + 32'(4 * k));
                        checkOutput("req_inst", bus.inst_enable, 0);
                    end
                    bus.mem_accept = 1'b1;
                    step();
                    bus.mem_accept = 1'b0;
                    checkOutput("req_drop", bus.addr_enable, 0);
                    if (k == fk) begin
                        flush = 1'b1;
                        step();
                        flush = 1'b0;
                        pend  = 1'b1;
                        checkOutput("flush_wait_inst", bus.inst_enable, 0);
                    end
                    if (k == reset_k) begin
                        rst = 1'b0;
                        step();
                        rst = 1'b1;
                        checkOutput("rst_addr_en", bus.addr_enable, 0);
                        checkOutput("rst_addr", bus.addr_to_mem, 0);
                        checkOutput("rst_inst", bus.inst_enable, 0);
                        model_clear();
                        bus.if_valid      = 1'b0;
                        bus.mem_valid     = 1'b1;
                        bus.inst_from_mem = 32'hDEADBEEF;
                        step();
                        bus.mem_valid = 1'b0;
                        checkOutput("stray_inst", bus.inst_enable, 0);
                        checkOutput("stray_req", bus.addr_enable, 0);
                        return;
                    end
                    repeat ($urandom_range(0, 2)) begin
                        step();
                        checkOutput("wait_inst", bus.inst_enable, 0);
                    end
                    bus.mem_valid     = 1'b1;
                    bus.inst_from_mem = mem_word(base + 32'(4 * k));
                    fwd = (k == int'(req[3:2])) && (bus.pc_from_if == req);
                    step();
                    bus.mem_valid = 1'b0;
                    checkOutput("fwd_en", bus.inst_enable, {31'b0, fwd});
                    if (fwd) checkOutput("fwd_data", bus.inst_to_if, mem_word(req));
                    if (k == sw) begin
                        cur = new_pc;
                        bus.pc_from_if = cur;
                    end
                end
                checkOutput("done_noreq", bus.addr_enable, 0);
                if (pend) model_clear();
                else model_fill(req);
                sw = -1;
                fk = -1;
                sk = -1;
            end
        end
        checkOutput("fetch_done", {31'b0, done}, 1);
        bus.if_valid = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        applyStimulus(pc, -1, 32'h0, -1, -1, -1);
    endtask

    task automatic flushIdle(input logic [31:0] pc);
        bus.if_valid   = 1'b1;
        bus.pc_from_if = pc;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.if_valid = 1'b0;
        checkOutput("flush_inst", bus.inst_enable, 0);
        checkOutput("flush_req", bus.addr_enable, 0);
        model_clear();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.if_valid      = 1'b0;
        bus.pc_from_if    = '0;
        bus.mem_accept    = 1'b0;
        bus.mem_valid     = 1'b0;
        bus.inst_from_mem = '0;
        model_clear();
        @(negedge clk);
        step();
        step();
        checkOutput("rst_inst_en", bus.inst_enable, 0);
        checkOutput("rst_inst", bus.inst_to_if, 0);
        checkOutput("rst_addr_en", bus.addr_enable, 0);
        checkOutput("rst_addr", bus.addr_to_mem, 0);
        rst = 1'b1;
        step();
        checkOutput("idle_inst", bus.inst_enable, 0);

        $display("[TB] cold miss and line hit");
        fetch(32'h1004);
        fetch(32'h100C);

        $display("[TB] replacement");
        fetch(32'h2000);
        fetch(32'h1000);
        fetch(32'h3000);
        fetch(32'h1000);
        fetch(32'h2000);

        $display("[TB] flush during refill");
        applyStimulus(32'h5000, -1, 32'h0, 2, -1, -1);
        fetch(32'h1000);

        $display("[TB] branch mid-refill");
        flushIdle(32'h1000);
        applyStimulus(32'h1000, 1, 32'h4000, -1, -1, -1);
        fetch(32'h1000);

        $display("[TB] reset mid-refill");
        applyStimulus(32'h6000, -1, 32'h0, -1, -1, 1);

        $display("[TB] stall in request");
        applyStimulus(32'h1008, -1, 32'h0, -1, 2, -1);
        fetch(32'h4000);
        rdy = 1'b0;
        bus.if_valid   = 1'b1;
        bus.pc_from_if = 32'h1008;
        repeat (3) begin
            step();
            checkOutput("stall_hit_inst", bus.inst_enable, 0);
        end
        rdy = 1'b1;
        fetch(32'h1008);

        $display("[TB] flush with coincident hit");
        flushIdle(32'h1008);
        fetch(32'h1008);

        $display("[TB] random fetches");
        for (int n = 0; n < 60; n++) begin
            logic [31:0] p, q;
            int sw, fk, sk;
            p  = randPc();
            q  = randPc();
            sw = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            fk = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
            sk = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
            if ($urandom_range(0, 14) == 0) flushIdle(p);
            applyStimulus(p, sw, q, fk, sk, -1);
            if ($urandom_range(0, 3) == 0) begin
                step();
                checkOutput("gap_inst", bus.inst_enable, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
